// File: rtl/mant_align_shifter.sv
// mant_align_shifter: multi-cycle right shifter aligning a mantissa and producing guard/round/sticky
module mant_align_shifter #(
    parameter int W  = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  mant_i,
    input  logic [EW-1:0] shift_i,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  mant_o,
    output logic          guard_o,
    output logic          round_o,
    output logic          sticky_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [31:0] SAT = 32'(W + 2);
    state_t        state_q, state_d;
    logic [W+1:0]  d_q, d_d;
    logic          sticky_q, sticky_d;
    logic [EW-1:0] cnt_q, cnt_d;
    logic          accept, sat;
    assign accept = start && state_q != SHIFT;
    // shifts of W+2 or more push every bit below round, so they resolve in one cycle
    assign sat = {{(32-EW){1'b0}}, shift_i} >= SAT;
    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (accept) begin
            d_d      = sat ? '0 : {mant_i, 2'b00};
            sticky_d = sat ? |mant_i : 1'b0;
            cnt_d    = shift_i;
            state_d  = (sat || shift_i == '0) ? DONE : SHIFT;
        end else if (state_q == SHIFT) begin
            sticky_d = sticky_q | d_q[0];
            d_d      = {1'b0, d_q[W+1:1]};
            cnt_d    = cnt_q - 1'b1;
            state_d  = (cnt_q == EW'(1)) ? DONE : SHIFT;
        end else if (state_q == DONE) begin
            state_d  = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            d_q      <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end
    assign busy     = state_q == SHIFT;
    assign done     = state_q == DONE;
    assign mant_o   = d_q[W+1:2];
    assign guard_o  = d_q[1];
    assign round_o  = d_q[0];
    assign sticky_o = sticky_q;
endmodule

// File: tb/tb_mant_align_shifter.sv
// tb_mant_align_shifter: directed vector bench for the mantissa alignment shifter
module tb_mant_align_shifter;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [23:0] mant_i = '0;
    logic [7:0]  shift_i = '0;
    logic        busy, done, guard_o, round_o, sticky_o;
    logic [23:0] mant_o;
    int n_cmp = 0;
    int n_err = 0;

    mant_align_shifter #(.W(24), .EW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mant_i(mant_i), .shift_i(shift_i),
        .busy(busy), .done(done), .mant_o(mant_o), .guard_o(guard_o),
        .round_o(round_o), .sticky_o(sticky_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] m;
        logic [7:0]  sh;
        logic [23:0] em;
        logic        eg, er, es;
    } vec_t;
    vec_t v[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [23:0] em, input logic eg, input logic er, input logic es);
        chk({tag, " mant"}, 32'(mant_o), 32'(em));
        chk({tag, " grs"}, {29'd0, guard_o, round_o, sticky_o}, {29'd0, eg, er, es});
    endtask

    task automatic run_op(input vec_t t);
        int lat, dc, bc;
        lat = (t.sh == 0 || t.sh >= 26) ? 1 : int'(t.sh) + 1;
        dc = 0;
        bc = 0;
        @(negedge clk);
        start = 1; mant_i = t.m; shift_i = t.sh;
        @(posedge clk);
        #1 start = 0; mant_i = '0; shift_i = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin dc = c; break; end
        end
        chk("latency", 32'(dc), 32'(lat));
        chk("busy_cycles", 32'(bc), 32'(lat - 1));
        chk_res("result", t.em, t.eg, t.er, t.es);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk_res("held", t.em, t.eg, t.er, t.es);
    endtask

    initial begin
        v[0] = '{24'hC00001, 8'd0,   24'hC00001, 1'b0, 1'b0, 1'b0};
        v[1] = '{24'h800007, 8'd3,   24'h100000, 1'b1, 1'b1, 1'b1};
        v[2] = '{24'h800000, 8'd25,  24'h000000, 1'b0, 1'b1, 1'b0};
        v[3] = '{24'h800000, 8'd26,  24'h000000, 1'b0, 1'b0, 1'b1};
        v[4] = '{24'h000001, 8'd255, 24'h000000, 1'b0, 1'b0, 1'b1};
        v[5] = '{24'hFFFFFF, 8'd24,  24'h000000, 1'b1, 1'b1, 1'b1};
        v[6] = '{24'hABCDEF, 8'd4,   24'h0ABCDE, 1'b1, 1'b1, 1'b1};
        v[7] = '{24'h123456, 8'd8,   24'h001234, 1'b0, 1'b1, 1'b1};
        v[8] = '{24'h000000, 8'd30,  24'h000000, 1'b0, 1'b0, 1'b0};
        v[9] = '{24'h800001, 8'd1,   24'h400000, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk_res("reset", 24'h0, 1'b0, 1'b0, 1'b0);
        rst = 0;

        foreach (v[i]) run_op(v[i]);

        // start pulsed again while busy must be ignored; a start in the done cycle is accepted
        @(negedge clk);
        start = 1; mant_i = 24'hC00001; shift_i = 8'd1;
        @(posedge clk);
        #1 mant_i = 24'hFFFFFF; shift_i = 8'd5;
        @(negedge clk);
        chk("b2b busy1", {30'd0, busy, done}, 32'd2);
        @(posedge clk);
        #1 mant_i = 24'h000003; shift_i = 8'd2;
        @(negedge clk);
        chk("b2b done1", {30'd0, busy, done}, 32'd1);
        chk_res("b2b first", 24'h600000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 0; mant_i = '0; shift_i = '0;
        @(negedge clk);
        chk("b2b busy2a", {30'd0, busy, done}, 32'd2);
        @(negedge clk);
        chk("b2b busy2b", {30'd0, busy, done}, 32'd2);
        @(negedge clk);
        chk("b2b done2", {30'd0, busy, done}, 32'd1);
        chk_res("b2b second", 24'h000000, 1'b1, 1'b1, 1'b0);

        // reset in the middle of a long shift
        @(negedge clk);
        start = 1; mant_i = 24'hFFFFFF; shift_i = 8'd10;
        @(posedge clk);
        #1 start = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk_res("rst", 24'h0, 1'b0, 1'b0, 1'b0);
        begin
            int dseen = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done || busy) dseen++;
            end
            chk("rst no activity", 32'(dseen), 32'd0);
        end
        run_op(v[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mant_align_shifter.md
# mant_align_shifter

Multi-cycle mantissa alignment shifter for the pipelined FP adder. It sits ahead of the bit-serial shift register stage. It captures the smaller operand's mantissa and the exponent difference, then right-shifts the mantissa one bit per cycle. During the shift it builds guard, round and sticky bits, and it hands the aligned result downstream with a one-cycle done pulse. Large exponent differences saturate in a single cycle, so a shift never runs past the mantissa width.

## Interface
Parameters:
- W, 24, mantissa width including hidden bit
- EW, 8, width of shift-amount (exponent difference) input

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when accepting (state IDLE or DONE)
- mant_i  input  W  mantissa to align
- shift_i  input  EW  right-shift amount, unsigned
- busy  output  1  high while state is SHIFT
- done  output  1  one-cycle pulse, high while state is DONE
- mant_o  output  W  aligned mantissa
- guard_o  output  1  first bit below mant_o LSB
- round_o  output  1  second bit below mant_o LSB
- sticky_o  output  1  OR of every bit shifted out below round position

## Operation
- Internal datapath register D[W+1:0] = {mant, guard, round}, plus a sticky flop and a down-counter cnt[EW-1:0].
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- Accept (IDLE or DONE, start=1). Next state is chosen by shift_i:
  - shift_i = 0: D ← {mant_i,2'b00}, sticky ← 0, go to DONE.
  - 1 ≤ shift_i ≤ W+1: D ← {mant_i,2'b00}, sticky ← 0, cnt ← shift_i, go to SHIFT.
  - shift_i ≥ W+2 (saturate): D ← 0, sticky ← |mant_i, go to DONE.
- SHIFT, each cycle:
  - sticky ← sticky | D[0].
  - D ← {1'b0, D[W+1:1]}.
  - cnt ← cnt−1.
  - When cnt = 1, go to DONE (this is the final shift).
- DONE:
  - If start=1, accept as above. Back-to-back operation is allowed.
  - Otherwise go to IDLE.
- Not accepting (SHIFT): start is ignored, and mant_i/shift_i are don't-care.
- Outputs: mant_o = D[W+1:2], guard_o = D[1], round_o = D[0], sticky_o = sticky flop.
  - Registered, and held from DONE until the next accept modifies D.
- Arithmetic: logical right shift with zero fill. The result equals mant_i·2^−shift_i truncated, with G/R/S exact.
- rst=1 at any edge, including mid-SHIFT, clears:
  - state → IDLE
  - D, sticky, cnt → 0
  - start on the same edge is ignored.

## Timing
- Reset values: busy=0, done=0, mant_o=0, guard_o=0, round_o=0, sticky_o=0.
- start accepted at edge of cycle 0. Latency:
  - 1 ≤ n ≤ W+1: busy high cycles 1..n, done high in cycle n+1.
  - n=0 or saturate: done high in cycle 1, busy stays 0.
- Maximum latency W+2 cycles (n=W+1).
- done is a single-cycle pulse unless a new accept in DONE produces another DONE on the next cycle (n=0 or saturate).
- Results are valid in the done cycle and remain stable through IDLE.
- Throughput: one operation per n+1 cycles; a new start may coincide with done.

## Test plan
- W=24. mant_i=0xC00001, shift_i=0 → done in cycle 1, mant_o=0xC00001, G=R=S=0, busy never high.
- mant_i=0x800007, shift_i=3 → busy cycles 1–3, done cycle 4, mant_o=0x100000, G=1, R=1, S=1.
- Boundary:
  - mant_i=0x800000, shift_i=25 → done cycle 26, mant_o=0, G=0, R=1, S=0.
  - shift_i=26 → done cycle 1, mant_o=0, G=R=0, S=1.
  - mant_i=0x000001, shift_i=255 → done cycle 1, S=1.
- mant_i=0xC00001, shift_i=1, with start re-pulsed with mant_i=0xFFFFFF in cycle 1 (busy) → ignored. Result mant_o=0x600000, G=1, R=0, S=0.
  - Then start with mant_i=0x000003, shift_i=2 during the done cycle → accepted, done 3 cycles later, mant_o=0, G=1, R=1, S=0.
- mant_i=0xFFFFFF, shift_i=10, rst asserted in cycle 4 (mid-SHIFT) → next cycle:
  - all outputs 0, state IDLE, no done pulse.
  - A fresh start then behaves as from power-up.
